// File: rtl/ame_pkg.sv
// ---------------------------------------------------------------------------
// ame_pkg
// Shared definitions for the AME gradient-sum datapath: default operand and
// accumulator widths, plus the accumulator state encoding.
// ---------------------------------------------------------------------------
package ame_pkg;

  localparam int AME_IN_DATA_BITS   = 16;
  localparam int AME_COMP_DATA_BITS = 64;

  // Block sequencing: accumulate samples, drain the product pipeline,
  // then present the final sum for one cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } accState_t;

endpackage

// File: rtl/ame_mul_reg.sv
// ---------------------------------------------------------------------------
// ame_mul_reg
// Registered full-precision signed multiplier with a product-valid flag.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_clear   synchronous clear of the valid flag (block restart)
//   i_en      capture a*b this cycle
//   i_a, i_b  signed multiplicands, IN_DATA_BITS each
//   o_prod    registered signed product, 2*IN_DATA_BITS
//   o_valid   o_prod holds a product not yet consumed
// ---------------------------------------------------------------------------
module ame_mul_reg
  import ame_pkg::*;
#(
  parameter int IN_DATA_BITS = AME_IN_DATA_BITS
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_clear,
  input  logic                            i_en,
  input  logic signed [IN_DATA_BITS-1:0]  i_a,
  input  logic signed [IN_DATA_BITS-1:0]  i_b,
  output logic signed [2*IN_DATA_BITS-1:0] o_prod,
  output logic                            o_valid
);

  localparam int PW = 2 * IN_DATA_BITS;

  logic signed [PW-1:0] w_aExt;
  logic signed [PW-1:0] w_bExt;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] r_prod;
  logic                 r_valid;

  // Extend operands explicitly so the low PW bits of the product are the
  // exact signed result.
  assign w_aExt = {{IN_DATA_BITS{i_a[IN_DATA_BITS-1]}}, i_a};
  assign w_bExt = {{IN_DATA_BITS{i_b[IN_DATA_BITS-1]}}, i_b};
  assign w_prod = w_aExt * w_bExt;

  // The valid flag follows i_en every cycle so each product is added once;
  // a clear wins so a restarted block never sees a stale product.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prod  <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_en;
      if (i_en) begin
        r_prod <= w_prod;
      end
    end
  end

  assign o_prod  = r_prod;
  assign o_valid = r_valid;

endmodule

// File: rtl/ame_sum_accum.sv
// ---------------------------------------------------------------------------
// ame_sum_accum
// Sums SAMPLE_CNT signed products a*b per block into a wrapping
// COMP_DATA_BITS accumulator and pulses comp_init_o when the sum is final.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_n_i       asynchronous active-low reset
//   accu_init_i   start pulse: clear and begin a block (any state)
//   accu_valid_i  qualifies accu_a_i / accu_b_i (only honoured in ACCUM)
//   accu_a_i      signed multiplicand
//   accu_b_i      signed multiplicand
//   accu_busy_o   high in ACCUM and DRAIN
//   comp_init_o   one-cycle pulse in DONE, sum valid
//   comp_data_o   accumulator value, signed
// ---------------------------------------------------------------------------
module ame_sum_accum
  import ame_pkg::*;
#(
  parameter int IN_DATA_BITS   = AME_IN_DATA_BITS,
  parameter int COMP_DATA_BITS = AME_COMP_DATA_BITS,
  parameter int SAMPLE_CNT     = 256
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             accu_init_i,
  input  logic                             accu_valid_i,
  input  logic signed [IN_DATA_BITS-1:0]   accu_a_i,
  input  logic signed [IN_DATA_BITS-1:0]   accu_b_i,
  output logic                             accu_busy_o,
  output logic                             comp_init_o,
  output logic signed [COMP_DATA_BITS-1:0] comp_data_o
);

  localparam int PW    = 2 * IN_DATA_BITS;
  localparam int CNT_W = $clog2(SAMPLE_CNT) + 1;

  accState_t r_state;
  accState_t w_nextState;

  logic [CNT_W-1:0]          r_cnt;
  logic signed [COMP_DATA_BITS-1:0] r_accum;

  logic                      w_take;
  logic                      w_lastTake;
  logic signed [PW-1:0]      w_prod;
  logic                      w_prodValid;
  logic signed [COMP_DATA_BITS-1:0] w_prodExt;

  // A sample is taken only in ACCUM and never on the init cycle itself.
  assign w_take     = (r_state == ST_ACCUM) && accu_valid_i && !accu_init_i;
  assign w_lastTake = w_take && (r_cnt == CNT_W'(SAMPLE_CNT - 1));

  ame_mul_reg #(
    .IN_DATA_BITS (IN_DATA_BITS)
  ) u_mulReg (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_clear (accu_init_i),
    .i_en    (w_take),
    .i_a     (accu_a_i),
    .i_b     (accu_b_i),
    .o_prod  (w_prod),
    .o_valid (w_prodValid)
  );

  assign w_prodExt = {{(COMP_DATA_BITS - PW){w_prod[PW-1]}}, w_prod};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // DRAIN exists to let the last registered product land in the
  // accumulator before DONE announces the sum.
  always_comb begin
    w_nextState = r_state;
    if (accu_init_i) begin
      w_nextState = ST_ACCUM;
    end else begin
      case (r_state)
        ST_IDLE:  w_nextState = ST_IDLE;
        ST_ACCUM: if (w_lastTake) w_nextState = ST_DRAIN;
        ST_DRAIN: w_nextState = ST_DONE;
        ST_DONE:  w_nextState = ST_IDLE;
        default:  w_nextState = ST_IDLE;
      endcase
    end
  end

  // Sample counter; the block leaves ACCUM at SAMPLE_CNT so it never wraps.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (accu_init_i) begin
      r_cnt <= '0;
    end else if (w_take) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Wrapping accumulator fed one cycle behind the multiplier.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_accum <= '0;
    end else if (accu_init_i) begin
      r_accum <= '0;
    end else if (w_prodValid) begin
      r_accum <= r_accum + w_prodExt;
    end
  end

  assign accu_busy_o = (r_state == ST_ACCUM) || (r_state == ST_DRAIN);
  assign comp_init_o = (r_state == ST_DONE);
  assign comp_data_o = r_accum;

endmodule

// File: tb/tb_ame_sum_accum.sv
// ---------------------------------------------------------------------------
// tb_ame_sum_accum
// Directed bench for ame_sum_accum with hand-computed block sums.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ame_sum_accum;

  logic        clk;
  logic        rst_n;
  logic        accuInit;
  logic        accuValid;
  logic signed [15:0] accuA;
  logic signed [15:0] accuB;
  logic        accuBusy;
  logic        compInit;
  logic signed [63:0] compData;

  int compared;
  int mismatched;
  int pulseCount;

  ame_sum_accum #(
    .IN_DATA_BITS   (16),
    .COMP_DATA_BITS (64),
    .SAMPLE_CNT     (256)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .accu_init_i  (accuInit),
    .accu_valid_i (accuValid),
    .accu_a_i     (accuA),
    .accu_b_i     (accuB),
    .accu_busy_o  (accuBusy),
    .comp_init_o  (compInit),
    .comp_data_o  (compData)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every DONE cycle seen at a sampling point counts as one pulse.
  always @(negedge clk) begin
    if (compInit) pulseCount <= pulseCount + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
               tag, $signed(observed), observed, $signed(expected), expected);
    end
  endtask

  // Drive one cycle of inputs and advance to the next sampling point.
  task automatic applyStimulus(input logic init, input logic valid,
                               input logic signed [15:0] a,
                               input logic signed [15:0] b);
    accuInit  = init;
    accuValid = valid;
    accuA     = a;
    accuB     = b;
    tick();
  endtask

  task automatic startBlock(input string tag);
    applyStimulus(1'b1, 1'b0, 16'sd0, 16'sd0);
    checkOutput({tag, "_busyAfterInit"}, {63'd0, accuBusy}, 64'd1);
  endtask

  task automatic feed(input int n, input logic signed [15:0] a,
                      input logic signed [15:0] b);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, a, b);
  endtask

  // Called right after the sampling point following the last accepting
  // edge; tailValid keeps valid high (a=b=7) through DRAIN/DONE/IDLE.
  task automatic finishBlock(input string tag, input logic [63:0] expSum,
                             input logic tailValid);
    int startPulses;
    startPulses = pulseCount;
    checkOutput({tag, "_noPulseInDrain"}, {63'd0, compInit}, 64'd0);
    applyStimulus(1'b0, tailValid, 16'sd7, 16'sd7);
    checkOutput({tag, "_pulseInDone"}, {63'd0, compInit}, 64'd1);
    checkOutput({tag, "_sum"}, compData, expSum);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, tailValid, 16'sd7, 16'sd7);
    checkOutput({tag, "_idleBusy"}, {63'd0, accuBusy}, 64'd0);
    checkOutput({tag, "_sumHeld"}, compData, expSum);
    checkOutput({tag, "_onePulse"}, 64'(pulseCount - startPulses), 64'd1);
    applyStimulus(1'b0, 1'b0, 16'sd0, 16'sd0);
  endtask

  initial begin
    int busyDrops;
    int earlyPulses;
    int pulsesBefore;
    compared   = 0;
    mismatched = 0;
    pulseCount = 0;
    rst_n      = 1'b0;
    accuInit   = 1'b0;
    accuValid  = 1'b0;
    accuA      = '0;
    accuB      = '0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_busy", {63'd0, accuBusy}, 64'd0);
    checkOutput("rst_init", {63'd0, compInit}, 64'd0);
    checkOutput("rst_data", compData, 64'd0);
    rst_n = 1'b1;
    tick();

    // 256 x (3 * -2) = -1536
    startBlock("basic");
    feed(256, 16'sd3, -16'sd2);
    finishBlock("basic", -64'sd1536, 1'b0);

    // 256 x (-32768)^2 = 2^38
    startBlock("extreme");
    feed(256, -16'sd32768, -16'sd32768);
    finishBlock("extreme", 64'd274877906944, 1'b0);

    // Valid toggling: 256 accepted samples need 511 cycles
    startBlock("toggle");
    busyDrops   = 0;
    earlyPulses = 0;
    for (int i = 0; i < 511; i++) begin
      applyStimulus(1'b0, (i % 2) == 0, 16'sd1, 16'sd1);
      if (i < 510 && !accuBusy) busyDrops++;
      if (compInit) earlyPulses++;
    end
    checkOutput("toggle_busyThroughout", 64'(busyDrops), 64'd0);
    checkOutput("toggle_noEarlyPulse", 64'(earlyPulses), 64'd0);
    finishBlock("toggle", 64'd256, 1'b0);

    // Restart mid-block; valid on the init cycle itself is ignored
    startBlock("restart");
    feed(100, 16'sd5, 16'sd5);
    pulsesBefore = pulseCount;
    applyStimulus(1'b1, 1'b1, 16'sd5, 16'sd5);
    checkOutput("restart_busy", {63'd0, accuBusy}, 64'd1);
    feed(256, 16'sd1, 16'sd1);
    finishBlock("restart", 64'd256, 1'b0);
    checkOutput("restart_totalPulses", 64'(pulseCount - pulsesBefore), 64'd1);

    // Valid in DRAIN/DONE/IDLE with a=b=7 must not disturb the sum
    startBlock("idleValid");
    feed(256, 16'sd1, 16'sd1);
    finishBlock("idleValid", 64'd256, 1'b1);
    feed(20, 16'sd7, 16'sd7);
    checkOutput("idleValid_sumAfterIdle", compData, 64'd256);
    checkOutput("idleValid_busy", {63'd0, accuBusy}, 64'd0);
    applyStimulus(1'b0, 1'b0, 16'sd0, 16'sd0);

    // Asynchronous reset mid-block
    startBlock("midReset");
    feed(50, 16'sd3, -16'sd2);
    pulsesBefore = pulseCount;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset_busy", {63'd0, accuBusy}, 64'd0);
    checkOutput("midReset_init", {63'd0, compInit}, 64'd0);
    checkOutput("midReset_data", compData, 64'd0);
    tick();
    rst_n = 1'b1;
    feed(300, 16'sd7, 16'sd7);
    checkOutput("midReset_ignoredBusy", {63'd0, accuBusy}, 64'd0);
    checkOutput("midReset_ignoredData", compData, 64'd0);
    checkOutput("midReset_noPulse", 64'(pulseCount - pulsesBefore), 64'd0);
    applyStimulus(1'b0, 1'b0, 16'sd0, 16'sd0);

    // A fresh block after reset still works
    startBlock("postReset");
    feed(256, 16'sd2, 16'sd2);
    finishBlock("postReset", 64'd1024, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ame_sum_accum.md
AME_SUM_ACCUM -- requirements
Module: ame_sum_accum

Interface
REQ-001 The module SHALL have these parameters:
- IN_DATA_BITS, default 16: signed width of each multiplicand.
- COMP_DATA_BITS, default 64: accumulator and output width.
- SAMPLE_CNT, default 256: products summed per block.
REQ-002 clk_i  input  1  single clock; all registers on rising edge.
REQ-003 rst_n_i  input  1  asynchronous, active-low reset.
REQ-004 accu_init_i  input  1  start pulse; clears the accumulator and begins a block.
REQ-005 accu_valid_i  input  1  sample qualifier for accu_a_i/accu_b_i.
REQ-006 accu_a_i  input  IN_DATA_BITS  signed multiplicand (gradient term).
REQ-007 accu_b_i  input  IN_DATA_BITS  signed multiplicand (gradient/residual term).
REQ-008 accu_busy_o  output  1  high in ACCUM and DRAIN states.
REQ-009 comp_init_o  output  1  one-cycle pulse; final sum valid; drives the downstream approximator's init.
REQ-010 comp_data_o  output  COMP_DATA_BITS  signed two's-complement sum; drives the downstream approximator's data input.

Function
REQ-011 The module SHALL implement a state machine with four states: IDLE, ACCUM, DRAIN, DONE.
REQ-012 Transitions SHALL be:
- IDLE->ACCUM on accu_init_i.
- ACCUM->DRAIN when the SAMPLE_CNT-th valid sample is accepted.
- DRAIN->DONE after 1 cycle.
- DONE->IDLE after 1 cycle.
REQ-013 On accu_init_i in any state, the module SHALL clear the accumulator, the sample counter and the product-valid flag, and enter ACCUM on the next edge; init has priority over all other events.
REQ-014 In ACCUM, each cycle with accu_valid_i=1 SHALL register the full-precision signed product a*b (2*IN_DATA_BITS bits) and increment the sample counter.
REQ-015 The registered product SHALL be sign-extended to COMP_DATA_BITS and added to the accumulator on the following edge, only when its product-valid flag is set.
REQ-016 Accumulation SHALL wrap modulo 2^COMP_DATA_BITS, with no saturation.
REQ-017 accu_valid_i SHALL be ignored outside ACCUM, including the accu_init_i cycle itself.
REQ-018 Gaps in accu_valid_i SHALL stall counting without affecting the sum.
REQ-019 comp_init_o SHALL be high exactly in DONE: 2 cycles after the edge accepting the last sample.
REQ-020 comp_data_o SHALL equal the accumulator register. It SHALL be stable from DONE until the next accu_init_i, and its value outside DONE/IDLE is don't-care.
REQ-021 The sample counter SHALL be $clog2(SAMPLE_CNT)+1 bits wide and SHALL never wrap within a block.

Reset
REQ-022 While rst_n_i=0, outputs and state SHALL be: state=IDLE; accumulator, counter, product register and product-valid flag=0; comp_init_o=0; accu_busy_o=0; comp_data_o=0.
REQ-023 Reset asserted mid-block SHALL abort the block with no comp_init_o pulse.
REQ-024 After reset release, the module SHALL require a new accu_init_i before accepting samples.

Structure
REQ-025 The state enum typedef and the default widths (IN_DATA_BITS, COMP_DATA_BITS) SHALL reside in the shared package ame_pkg.
REQ-026 The multiply register and product-valid flag SHALL form one sub-module, ame_mul_reg; counter, FSM and accumulator SHALL stay in ame_sum_accum.

Verification
REQ-027 Reset, then init, then 256 samples of a=3, b=-2 back-to-back -> comp_init_o pulses once, 2 cycles after the last sample, with comp_data_o = -1536.
REQ-028 Extremes: 256 samples of a=-32768, b=-32768 -> comp_data_o = 274877906944 (2^38), with no truncation.
REQ-029 Valid toggling 1,0,1,0 with a=1, b=1 -> comp_init_o only after the 256th accepted sample, comp_data_o = 256, and accu_busy_o high throughout.
REQ-030 Init re-asserted after 100 samples of a=b=5, then 256 samples of a=b=1 -> comp_data_o = 256 and exactly one comp_init_o pulse.
REQ-031 rst_n_i pulsed low after 50 samples -> all outputs 0 immediately (asynchronous); no comp_init_o; valid samples ignored until the next init.
REQ-032 Valid asserted in IDLE and DONE with a=b=7 -> accumulator unchanged, and comp_data_o holds the previous sum.
